// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: word-level controller for the C-PHY HS transmit path.
// Sequences one HS burst per TxRequestHS assertion: preamble words, sync word,
// payload words from the symbol mapper, then post words. Words are held for
// seven symbol clocks (Phase 0..6); the serializer loads them inside Phase 0.
// Optional feature macro: HS_TX_UNDERFLOW_FILL_EN (defined: an underflow emits
// the sync word as filler and stays in DATA; undefined: an underflow ends the
// burst through POST).
`timescale 1ns/1ps

module hs_tx_sequencer #(
  parameter int unsigned PREBEGIN_WORDS = 4,
  parameter int unsigned POST_WORDS     = 1
) (
  input  logic       TxSymbolClkHS,
  input  logic       RstN,
  input  logic       TxRequestHS,
  input  logic [6:0] TxWordPolarity,
  input  logic [6:0] TxWordRotation,
  input  logic [6:0] TxWordFlip,
  input  logic       TxWordValid,
  output logic       TxWordReady,
  output logic [6:0] TxPolarity,
  output logic [6:0] TxRotation,
  output logic [6:0] TxFlip,
  output logic       HsSerializerEn,
  output logic       TxReadyHS,
  output logic       TxUnderflow,
  output logic       HsActive
);

  typedef enum logic [2:0] {
    IDLE,
    PREBEGIN,
    SYNC,
    DATA,
    POST
  } state_t;

  // Symbol encoding {Flip, Rotation, Polarity}: '3' = 011, '4' = 100
  localparam logic [6:0] PRE_FLIP  = 7'h00;
  localparam logic [6:0] PRE_ROT   = 7'h7F;
  localparam logic [6:0] PRE_POL   = 7'h7F;
  localparam logic [6:0] SYNC_FLIP = 7'b0111110;
  localparam logic [6:0] SYNC_ROT  = 7'b1000001;
  localparam logic [6:0] SYNC_POL  = 7'b1000001;
  localparam logic [6:0] POST_FLIP = 7'h7F;
  localparam logic [6:0] POST_ROT  = 7'h00;
  localparam logic [6:0] POST_POL  = 7'h00;

  localparam logic [7:0] PRE_LAST  = 8'(PREBEGIN_WORDS - 1);
  localparam logic [7:0] POST_LAST = 8'(POST_WORDS - 1);

  state_t     state;
  logic [2:0] phase;
  logic [7:0] wordCnt;
  logic       readyWin;
  logic       wrap;

  // Last symbol of the current word: next posedge presents a new word
  assign wrap = HsSerializerEn && (phase == 3'd6);

  // The accept window is registered; the request level gates it so that a
  // dropped request at Phase 6 never produces a ready pulse.
  assign TxWordReady = readyWin & TxRequestHS;

  assign HsActive = (state != IDLE);

  // Burst FSM with phase counter, word counter and registered word outputs
  always_ff @(posedge TxSymbolClkHS or negedge RstN) begin
    if (!RstN) begin
      state          <= IDLE;
      phase          <= '0;
      wordCnt        <= '0;
      readyWin       <= 1'b0;
      HsSerializerEn <= 1'b0;
      TxReadyHS      <= 1'b0;
      TxUnderflow    <= 1'b0;
      TxFlip         <= '0;
      TxRotation     <= '0;
      TxPolarity     <= '0;
    end else begin
      readyWin <= 1'b0;
      if (HsSerializerEn) begin
        phase <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;
      end
      if (HsSerializerEn && (phase == 3'd5) && (state == SYNC || state == DATA)) begin
        readyWin <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (TxRequestHS) begin
            state          <= PREBEGIN;
            HsSerializerEn <= 1'b1;
            phase          <= '0;
            wordCnt        <= '0;
            TxUnderflow    <= 1'b0;
            TxFlip         <= PRE_FLIP;
            TxRotation     <= PRE_ROT;
            TxPolarity     <= PRE_POL;
          end
        end

        PREBEGIN: begin
          if (wrap) begin
            if (wordCnt == PRE_LAST) begin
              state      <= SYNC;
              TxFlip     <= SYNC_FLIP;
              TxRotation <= SYNC_ROT;
              TxPolarity <= SYNC_POL;
            end else begin
              wordCnt <= wordCnt + 8'd1;
            end
          end
        end

        // SYNC and DATA both end their word with an accept window; a request
        // dropped before the sync wrap goes straight to POST with no payload.
        SYNC, DATA: begin
          if (wrap) begin
            if (!TxRequestHS) begin
              state      <= POST;
              wordCnt    <= '0;
              TxReadyHS  <= 1'b0;
              TxFlip     <= POST_FLIP;
              TxRotation <= POST_ROT;
              TxPolarity <= POST_POL;
            end else if (TxWordValid) begin
              state      <= DATA;
              TxReadyHS  <= 1'b1;
              TxFlip     <= TxWordFlip;
              TxRotation <= TxWordRotation;
              TxPolarity <= TxWordPolarity;
            end else begin
              TxUnderflow <= 1'b1;
`ifdef HS_TX_UNDERFLOW_FILL_EN
              state      <= DATA;
              TxReadyHS  <= 1'b1;
              TxFlip     <= SYNC_FLIP;
              TxRotation <= SYNC_ROT;
              TxPolarity <= SYNC_POL;
`else
              state      <= POST;
              wordCnt    <= '0;
              TxReadyHS  <= 1'b0;
              TxFlip     <= POST_FLIP;
              TxRotation <= POST_ROT;
              TxPolarity <= POST_POL;
`endif
            end
          end
        end

        POST: begin
          if (wrap) begin
            if (wordCnt == POST_LAST) begin
              state          <= IDLE;
              HsSerializerEn <= 1'b0;
              phase          <= '0;
              wordCnt        <= '0;
              TxFlip         <= '0;
              TxRotation     <= '0;
              TxPolarity     <= '0;
            end else begin
              wordCnt <= wordCnt + 8'd1;
            end
          end
        end

        default: begin
          state          <= IDLE;
          HsSerializerEn <= 1'b0;
          TxReadyHS      <= 1'b0;
        end
      endcase
    end
  end

endmodule
